// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, baud tick, 3-sample majority vote,
// false-start reject, held output register with read handshake.
// Ports: clk, rst_n (async low), ser_in, rx_rd, err_clr -> dout, rx_valid,
//        parity_err, frame_err, break_det, overrun_err (sticky), busy.
module uart_rx_param #(
  parameter int CLK_DIV     = 27,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ser_in,
  input  logic                 rx_rd,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int DW  = $clog2(CLK_DIV) + 1;
  localparam int SW  = $clog2(OVERSAMPLE) + 1;
  localparam int BW  = $clog2(DATA_BITS + 2) + 1;
  localparam int MID = OVERSAMPLE / 2;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] S_LO     = SW'(MID - 1);
  localparam logic [SW-1:0] S_MD     = SW'(MID);
  localparam logic [SW-1:0] S_HI     = SW'(MID + 1);
  localparam logic [SW-1:0] S_END    = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_DLAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_SLAST  = BW'(STOP_BITS - 1);
  localparam logic          ODD      = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP, DONE, BRKWAIT
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          div_cnt;
  logic [SW-1:0]          sample_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   v0, v1;
  logic                   pe_p, fe_p, pbit0;
  logic                   line, tick, vote, exp_par, brk;

  assign line    = sync_q[SYNC_STAGES-1];
  assign tick    = (div_cnt == DIV_LAST);
  assign vote    = (v0 & v1) | (v0 & line) | (v1 & line);
  assign exp_par = (^shreg) ^ ODD;
  // fe_p doubles as "some stop bit was 0", which a break requires
  assign brk     = (shreg == '0) && fe_p && ((PARITY == 0) || pbit0);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ser_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      v0          <= 1'b1;
      v1          <= 1'b1;
      pe_p        <= 1'b0;
      fe_p        <= 1'b0;
      pbit0       <= 1'b0;
      dout        <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      break_det   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      // defaults first; DONE below overrides (set wins)
      if (err_clr) overrun_err <= 1'b0;
      if (rx_rd) rx_valid <= 1'b0;
      if (tick && sample_cnt == S_LO) v0 <= line;
      if (tick && sample_cnt == S_MD) v1 <= line;

      unique case (state)
        IDLE: begin
          if (tick && !line) begin
            state      <= START;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            pe_p       <= 1'b0;
            fe_p       <= 1'b0;
            pbit0      <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            if (sample_cnt == S_HI && vote) begin
              state <= IDLE;
            end else if (sample_cnt == S_END) begin
              state      <= DATA;
              sample_cnt <= '0;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sample_cnt == S_HI)
              shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (sample_cnt == S_END) begin
              sample_cnt <= '0;
              if (bit_cnt == B_DLAST) begin
                bit_cnt <= '0;
                state   <= (PARITY != 0) ? PAR : STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        PAR: begin
          if (tick) begin
            if (sample_cnt == S_HI) begin
              pe_p  <= (vote != exp_par);
              pbit0 <= !vote;
            end
            if (sample_cnt == S_END) begin
              sample_cnt <= '0;
              state      <= STOP;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (sample_cnt == S_HI && !vote) fe_p <= 1'b1;
            // leave half a bit early so the next start edge is not missed
            if (sample_cnt == S_HI && bit_cnt == B_SLAST) begin
              state <= DONE;
            end else if (sample_cnt == S_END) begin
              sample_cnt <= '0;
              bit_cnt    <= bit_cnt + 1'b1;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (!rx_valid || rx_rd) begin
            dout       <= shreg;
            parity_err <= pe_p;
            frame_err  <= fe_p;
            break_det  <= brk;
            rx_valid   <= 1'b1;
          end else begin
            overrun_err <= 1'b1;
          end
          state <= brk ? BRKWAIT : IDLE;
        end
        BRKWAIT: begin
          if (tick && line) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1 instance (CLK_DIV=1) and an
// 8E2 instance (CLK_DIV=2, OVERSAMPLE=8); scoreboard of expected frames.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic ser_n = 1'b1, rd_n = 1'b0, clr_n = 1'b0;
  logic ser_e = 1'b1, rd_e = 1'b0, clr_e = 1'b0;

  logic [7:0] dout_n, dout_e;
  logic v_n, pe_n, fe_n, brk_n, ovr_n, busy_n;
  logic v_e, pe_e, fe_e, brk_e, ovr_e, busy_e;

  uart_rx_param #(
    .CLK_DIV(1), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)
  ) u_n (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_n),
    .rx_rd(rd_n), .err_clr(clr_n), .dout(dout_n),
    .rx_valid(v_n), .parity_err(pe_n), .frame_err(fe_n),
    .break_det(brk_n), .overrun_err(ovr_n), .busy(busy_n)
  );

  uart_rx_param #(
    .CLK_DIV(2), .OVERSAMPLE(8), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(2)
  ) u_e (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_e),
    .rx_rd(rd_e), .err_clr(clr_e), .dout(dout_e),
    .rx_valid(v_e), .parity_err(pe_e), .frame_err(fe_e),
    .break_det(brk_e), .overrun_err(ovr_e), .busy(busy_e)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = -1;
  int start_cyc = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v_n && !prev_v) rise_cyc = cyc;
    prev_v = v_n;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] frame_n(input logic [7:0] d,
                                         input logic stop);
    return {6'b0, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame_e(input logic [7:0] d,
                                         input logic p,
                                         input logic stop);
    return {4'b0, stop, stop, p, d, 1'b0};
  endfunction

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // each bit lasts 16 clk on both instances
  task automatic send_bits(input bit which,
                           input logic [15:0] bits,
                           input int n);
    for (int i = 0; i < n; i++) begin
      if (which) ser_e = bits[i];
      else ser_n = bits[i];
      repeat (16) @(posedge clk);
      #1;
    end
    if (which) ser_e = 1'b1;
    else ser_n = 1'b1;
  endtask

  task automatic wait_valid(input bit which, input string tag);
    int n = 0;
    while (!(which ? v_e : v_n) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, (which ? v_e : v_n)}, 32'd1);
  endtask

  task automatic pop_check(input bit which, input string tag);
    exp_t e;
    logic [10:0] obs;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s: observed empty scoreboard expected a frame", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      obs = which ? {dout_e, pe_e, fe_e, brk_e}
                  : {dout_n, pe_n, fe_n, brk_n};
      chk(tag, {21'b0, obs}, {21'b0, e});
    end
  endtask

  task automatic rd(input bit which);
    align();
    if (which) rd_e = 1'b1;
    else rd_n = 1'b1;
    align();
    rd_n = 1'b0;
    rd_e = 1'b0;
  endtask

  function automatic logic [31:0] outs_n();
    return {18'b0, dout_n, v_n, pe_n, fe_n, brk_n, ovr_n, busy_n};
  endfunction

  function automatic logic [31:0] outs_e();
    return {18'b0, dout_e, v_e, pe_e, fe_e, brk_e, ovr_e, busy_e};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_n", outs_n(), 32'd0);
    chk("reset_e", outs_e(), 32'd0);
    align();
    rst_n = 1'b1;
    idle(8);

    // T1: 8N1 0xA5 and its latency
    align();
    start_cyc = cyc;
    sb.push_back({8'hA5, 3'b000});
    send_bits(0, frame_n(8'hA5, 1'b1), 10);
    wait_valid(0, "t1_valid");
    pop_check(0, "t1_frame");
    chk("t1_ovr", {31'b0, ovr_n}, 32'd0);
    // 2 sync + 1 detect + 154 ticks to last stop sample + 1 DONE
    chk("t1_latency", rise_cyc - start_cyc, 32'd158);
    rd(0);
    chk("t1_read", {23'b0, v_n, dout_n}, {23'b0, 1'b0, 8'hA5});

    // T2: even parity, wrong then right parity bit
    idle(8);
    sb.push_back({8'h03, (1'b1 != ^8'h03), 2'b00});
    send_bits(1, frame_e(8'h03, 1'b1, 1'b1), 12);
    wait_valid(1, "t2_valid_bad");
    pop_check(1, "t2_bad_parity");
    rd(1);
    idle(8);
    sb.push_back({8'h03, (1'b0 != ^8'h03), 2'b00});
    send_bits(1, frame_e(8'h03, 1'b0, 1'b1), 12);
    wait_valid(1, "t2_valid_good");
    pop_check(1, "t2_good_parity");
    rd(1);

    // T3: 4-tick low glitch
    idle(8);
    ser_n = 1'b0;
    idle(4);
    ser_n = 1'b1;
    idle(2);
    chk("t3_busy_glitch", {31'b0, busy_n}, 32'd1);
    idle(40);
    chk("t3_rejected", {30'b0, v_n, busy_n}, 32'd0);

    // T4: framing error, then break
    sb.push_back({8'h55, 3'b010});
    send_bits(0, frame_n(8'h55, 1'b0), 10);
    idle(48);
    wait_valid(0, "t4_valid_fe");
    pop_check(0, "t4_frame_err");
    rd(0);
    sb.push_back({8'h00, 3'b011});
    ser_n = 1'b0;
    idle(240);
    wait_valid(0, "t4_valid_brk");
    pop_check(0, "t4_break");
    rd(0);
    idle(240);
    chk("t4_brk_hold", {30'b0, v_n, busy_n}, 32'd1);
    ser_n = 1'b1;
    idle(48);
    chk("t4_brk_end", {30'b0, v_n, busy_n}, 32'd0);
    sb.push_back({8'h3C, 3'b000});
    send_bits(0, frame_n(8'h3C, 1'b1), 10);
    wait_valid(0, "t4_valid_3c");
    pop_check(0, "t4_after_break");
    rd(0);

    // T5: overrun, clear, read in DONE
    idle(8);
    sb.push_back({8'h11, 3'b000});
    send_bits(0, frame_n(8'h11, 1'b1), 10);
    wait_valid(0, "t5_valid_11");
    pop_check(0, "t5_first");
    idle(16);
    send_bits(0, frame_n(8'h22, 1'b1), 10);
    idle(16);
    chk("t5_overrun", {22'b0, v_n, dout_n, ovr_n},
        {22'b0, 1'b1, 8'h11, 1'b1});
    align();
    clr_n = 1'b1;
    align();
    clr_n = 1'b0;
    chk("t5_clr", {30'b0, v_n, ovr_n}, 32'd2);
    idle(8);
    sb.push_back({8'h22, 3'b000});
    fork
      send_bits(0, frame_n(8'h22, 1'b1), 10);
      begin
        repeat (157) @(posedge clk);
        #1 rd_n = 1'b1;
        @(posedge clk);
        #1 rd_n = 1'b0;
      end
    join
    wait_valid(0, "t5_valid_22");
    pop_check(0, "t5_rd_in_done");
    chk("t5_no_overrun", {31'b0, ovr_n}, 32'd0);

    // T6: async reset mid-DATA with unread data held
    idle(8);
    fork
      send_bits(0, frame_n(8'hFF, 1'b1), 10);
      begin
        repeat (60) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_reset_n", outs_n(), 32'd0);
        chk("t6_reset_e", outs_e(), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    idle(32);
    chk("t6_discarded", {30'b0, v_n, busy_n}, 32'd0);
    sb.push_back({8'h5A, 3'b000});
    send_bits(0, frame_n(8'h5A, 1'b1), 10);
    wait_valid(0, "t6_valid_5a");
    pop_check(0, "t6_frame");
    chk("t6_ovr", {31'b0, ovr_n}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
